// File: rtl/pipeline_pkg.sv
// Shared pipeline types: datapath width, CSR/ALU encodings and the control bundle
// carried from decode through the execute and memory stage registers.
package pipeline_pkg;

    localparam int XLEN  = 32;
    localparam int ALU_W = 4;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    typedef enum logic [ALU_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_PASS = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             alu_src;
        logic             branch;
        logic             jump;
        logic             csr_write;
        logic [1:0]       csr_op;
        logic [ALU_W-1:0] alu_control;
    } ctrl_t;

    // An invalid slot may carry junk decode; strip everything that could act on state.
    function automatic ctrl_t kill_ctrl(ctrl_t c);
        ctrl_t k;
        k             = c;
        k.reg_write   = 1'b0;
        k.mem_read    = 1'b0;
        k.mem_write   = 1'b0;
        k.branch      = 1'b0;
        k.jump        = 1'b0;
        k.csr_write   = 1'b0;
        k.csr_op      = CSR_NONE;
        k.alu_control = '0;
        return k;
    endfunction

endpackage

// File: rtl/id_ex_pipeline_reg_if.sv
// Decode/execute boundary bundle: D-side fields in, E-side registered copies and stalls out.
interface id_ex_pipeline_reg_if #(
    parameter int XLEN   = 32,
    parameter int BCNT_W = 16
);
    import pipeline_pkg::*;

    logic              FlushE;
    logic              ValidD;
    logic              RegWriteD, MemReadD, MemWriteD, ALUSrcD, BranchD, JumpD, CSRWriteD;
    logic [ALU_W-1:0]  ALUControlD;
    logic [1:0]        CSROpD;
    logic [11:0]       CSRAddrD;
    logic              UsesRs1D, UsesRs2D;
    logic [4:0]        Rs1_D, Rs2_D, RD_D;
    logic [XLEN-1:0]   RD1_D, RD2_D, Imm_Ext_D, PCD, PCPlus4D;

    logic              ValidE;
    logic              RegWriteE, MemReadE, MemWriteE, ALUSrcE, BranchE, JumpE, CSRWriteE;
    logic [ALU_W-1:0]  ALUControlE;
    logic [1:0]        CSROpE;
    logic [11:0]       CSRAddrE;
    logic              UsesRs1E, UsesRs2E;
    logic [4:0]        Rs1_E, Rs2_E, RD_E;
    logic [XLEN-1:0]   RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;

    logic              StallF, StallD;
    logic [BCNT_W-1:0] BubbleCount;

    modport master (
        output FlushE, ValidD, RegWriteD, MemReadD, MemWriteD, ALUSrcD, BranchD, JumpD,
               CSRWriteD, ALUControlD, CSROpD, CSRAddrD, UsesRs1D, UsesRs2D,
               Rs1_D, Rs2_D, RD_D, RD1_D, RD2_D, Imm_Ext_D, PCD, PCPlus4D,
        input  ValidE, RegWriteE, MemReadE, MemWriteE, ALUSrcE, BranchE, JumpE,
               CSRWriteE, ALUControlE, CSROpE, CSRAddrE, UsesRs1E, UsesRs2E,
               Rs1_E, Rs2_E, RD_E, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E,
               StallF, StallD, BubbleCount
    );

    modport slave (
        input  FlushE, ValidD, RegWriteD, MemReadD, MemWriteD, ALUSrcD, BranchD, JumpD,
               CSRWriteD, ALUControlD, CSROpD, CSRAddrD, UsesRs1D, UsesRs2D,
               Rs1_D, Rs2_D, RD_D, RD1_D, RD2_D, Imm_Ext_D, PCD, PCPlus4D,
        output ValidE, RegWriteE, MemReadE, MemWriteE, ALUSrcE, BranchE, JumpE,
               CSRWriteE, ALUControlE, CSROpE, CSRAddrE, UsesRs1E, UsesRs2E,
               Rs1_E, Rs2_E, RD_E, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E,
               StallF, StallD, BubbleCount
    );

endinterface

// File: rtl/id_ex_pipeline_reg_interlock.sv
// Load-use and CSR read-after-write detection between the D and E slots.
module id_ex_interlock (
    input  logic        valid_d,
    input  logic        valid_e,
    input  logic        mem_read_e,
    input  logic        csr_write_e,
    input  logic [4:0]  rd_e,
    input  logic        uses_rs1,
    input  logic        uses_rs2,
    input  logic [4:0]  rs1_d,
    input  logic [4:0]  rs2_d,
    input  logic [1:0]  csr_op_d,
    input  logic [11:0] csr_addr_d,
    input  logic [11:0] csr_addr_e,
    input  logic        flush,
    output logic        lu,
    output logic        cs,
    output logic        ilk
);
    import pipeline_pkg::*;

    assign lu = valid_d && valid_e && mem_read_e && (rd_e != 5'd0) &&
                ((uses_rs1 && (rs1_d == rd_e)) || (uses_rs2 && (rs2_d == rd_e)));

    assign cs = valid_d && valid_e && csr_write_e &&
                (csr_op_d != CSR_NONE) && (csr_addr_d == csr_addr_e);

    // A flush discards the D instruction, so stalling it would only waste a cycle.
    assign ilk = (lu || cs) && !flush;

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with interlock bubble insertion and a saturating bubble counter.
module id_ex_pipeline_reg #(
    parameter int XLEN   = 32,
    parameter int BCNT_W = 16
) (
    input logic                 clk,
    input logic                 rst,
    id_ex_pipeline_reg_if.slave bus
);
    import pipeline_pkg::*;

    ctrl_t             ctrl_d, ctrl_e;
    logic              valid_e;
    logic              uses_rs1_e, uses_rs2_e;
    logic [11:0]       csr_addr_e;
    logic [4:0]        rs1_e, rs2_e, rd_e;
    logic [XLEN-1:0]   rd1_e, rd2_e, imm_e, pc_e, pc4_e;
    logic [BCNT_W-1:0] bubble_count;
    logic              lu, cs, ilk;

    assign ctrl_d = '{reg_write: bus.RegWriteD, mem_read: bus.MemReadD, mem_write: bus.MemWriteD,
                      alu_src: bus.ALUSrcD, branch: bus.BranchD, jump: bus.JumpD,
                      csr_write: bus.CSRWriteD, csr_op: bus.CSROpD, alu_control: bus.ALUControlD};

    id_ex_interlock u_interlock (
        .valid_d     (bus.ValidD),
        .valid_e     (valid_e),
        .mem_read_e  (ctrl_e.mem_read),
        .csr_write_e (ctrl_e.csr_write),
        .rd_e        (rd_e),
        .uses_rs1    (bus.UsesRs1D),
        .uses_rs2    (bus.UsesRs2D),
        .rs1_d       (bus.Rs1_D),
        .rs2_d       (bus.Rs2_D),
        .csr_op_d    (bus.CSROpD),
        .csr_addr_d  (bus.CSRAddrD),
        .csr_addr_e  (csr_addr_e),
        .flush       (bus.FlushE),
        .lu          (lu),
        .cs          (cs),
        .ilk         (ilk)
    );

    // Flush and interlock both insert a fully zeroed bubble, so RD_E=0 can never forward.
    always_ff @(posedge clk) begin
        if (rst || bus.FlushE || ilk) begin
            valid_e    <= 1'b0;
            ctrl_e     <= '0;
            uses_rs1_e <= 1'b0;
            uses_rs2_e <= 1'b0;
            csr_addr_e <= '0;
            rs1_e      <= '0;
            rs2_e      <= '0;
            rd_e       <= '0;
            rd1_e      <= '0;
            rd2_e      <= '0;
            imm_e      <= '0;
            pc_e       <= '0;
            pc4_e      <= '0;
        end else begin
            valid_e    <= bus.ValidD;
            ctrl_e     <= bus.ValidD ? ctrl_d : kill_ctrl(ctrl_d);
            uses_rs1_e <= bus.UsesRs1D;
            uses_rs2_e <= bus.UsesRs2D;
            csr_addr_e <= bus.CSRAddrD;
            rs1_e      <= bus.Rs1_D;
            rs2_e      <= bus.Rs2_D;
            rd_e       <= bus.RD_D;
            rd1_e      <= bus.RD1_D;
            rd2_e      <= bus.RD2_D;
            imm_e      <= bus.Imm_Ext_D;
            pc_e       <= bus.PCD;
            pc4_e      <= bus.PCPlus4D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            bubble_count <= '0;
        else if (ilk && (bubble_count != {BCNT_W{1'b1}}))
            bubble_count <= bubble_count + BCNT_W'(1);
    end

    assign bus.ValidE      = valid_e;
    assign bus.RegWriteE   = ctrl_e.reg_write;
    assign bus.MemReadE    = ctrl_e.mem_read;
    assign bus.MemWriteE   = ctrl_e.mem_write;
    assign bus.ALUSrcE     = ctrl_e.alu_src;
    assign bus.BranchE     = ctrl_e.branch;
    assign bus.JumpE       = ctrl_e.jump;
    assign bus.CSRWriteE   = ctrl_e.csr_write;
    assign bus.CSROpE      = ctrl_e.csr_op;
    assign bus.ALUControlE = ctrl_e.alu_control;
    assign bus.CSRAddrE    = csr_addr_e;
    assign bus.UsesRs1E    = uses_rs1_e;
    assign bus.UsesRs2E    = uses_rs2_e;
    assign bus.Rs1_E       = rs1_e;
    assign bus.Rs2_E       = rs2_e;
    assign bus.RD_E        = rd_e;
    assign bus.RD1_E       = rd1_e;
    assign bus.RD2_E       = rd2_e;
    assign bus.Imm_Ext_E   = imm_e;
    assign bus.PCE         = pc_e;
    assign bus.PCPlus4E    = pc4_e;
    assign bus.StallF      = ilk;
    assign bus.StallD      = ilk;
    assign bus.BubbleCount = bubble_count;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Randomized + directed bench for id_ex_pipeline_reg against a slot-level reference model.
module tb_id_ex_pipeline_reg;

    localparam int XLEN   = 32;
    localparam int BCNT_W = 8;
    localparam logic [BCNT_W-1:0] CNT_MAX = {BCNT_W{1'b1}};

    typedef struct packed {
        logic        RegWrite, MemRead, MemWrite, ALUSrc, Branch, Jump, CSRWrite;
        logic [3:0]  ALUControl;
        logic [1:0]  CSROp;
        logic [11:0] CSRAddr;
        logic        UsesRs1, UsesRs2;
        logic [4:0]  Rs1, Rs2, RD;
        logic [31:0] RD1, RD2, Imm, PC, PC4;
    } slot_t;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    slot_t m_slot;
    logic  m_valid;
    int    m_count;

    id_ex_pipeline_reg_if #(.XLEN(XLEN), .BCNT_W(BCNT_W)) bus ();

    id_ex_pipeline_reg #(.XLEN(XLEN), .BCNT_W(BCNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] pickReg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd5;
            2:       return 5'd6;
            default: return 5'($urandom);
        endcase
    endfunction

    function automatic slot_t randomSlot();
        slot_t s;
        s.RegWrite   = 1'($urandom);
        s.MemRead    = 1'($urandom);
        s.MemWrite   = 1'($urandom);
        s.ALUSrc     = 1'($urandom);
        s.Branch     = 1'($urandom);
        s.Jump       = 1'($urandom);
        s.CSRWrite   = 1'($urandom);
        s.ALUControl = 4'($urandom);
        s.CSROp      = 2'($urandom);
        s.CSRAddr    = ($urandom_range(0, 1) == 0) ? 12'h300 : 12'h305;
        s.UsesRs1    = 1'($urandom);
        s.UsesRs2    = 1'($urandom);
        s.Rs1        = pickReg();
        s.Rs2        = pickReg();
        s.RD         = pickReg();
        s.RD1        = $urandom;
        s.RD2        = $urandom;
        s.Imm        = $urandom;
        s.PC         = $urandom;
        s.PC4        = $urandom;
        return s;
    endfunction

    function automatic slot_t observedE();
        return '{bus.RegWriteE, bus.MemReadE, bus.MemWriteE, bus.ALUSrcE, bus.BranchE, bus.JumpE,
                 bus.CSRWriteE, bus.ALUControlE, bus.CSROpE, bus.CSRAddrE, bus.UsesRs1E, bus.UsesRs2E,
                 bus.Rs1_E, bus.Rs2_E, bus.RD_E, bus.RD1_E, bus.RD2_E, bus.Imm_Ext_E, bus.PCE, bus.PCPlus4E};
    endfunction

    task automatic driveD(input slot_t s, input logic valid, input logic flush, input logic r);
        rst             = r;
        bus.FlushE      = flush;
        bus.ValidD      = valid;
        bus.RegWriteD   = s.RegWrite;
        bus.MemReadD    = s.MemRead;
        bus.MemWriteD   = s.MemWrite;
        bus.ALUSrcD     = s.ALUSrc;
        bus.BranchD     = s.Branch;
        bus.JumpD       = s.Jump;
        bus.CSRWriteD   = s.CSRWrite;
        bus.ALUControlD = s.ALUControl;
        bus.CSROpD      = s.CSROp;
        bus.CSRAddrD    = s.CSRAddr;
        bus.UsesRs1D    = s.UsesRs1;
        bus.UsesRs2D    = s.UsesRs2;
        bus.Rs1_D       = s.Rs1;
        bus.Rs2_D       = s.Rs2;
        bus.RD_D        = s.RD;
        bus.RD1_D       = s.RD1;
        bus.RD2_D       = s.RD2;
        bus.Imm_Ext_D   = s.Imm;
        bus.PCD         = s.PC;
        bus.PCPlus4D    = s.PC4;
    endtask

    // Reference rule: does the instruction in D depend on an unfinished load or CSR write in E?
    function automatic logic expectInterlock(input slot_t d, input logic valid, input logic flush);
        logic load_use, csr_raw;
        load_use = valid && m_valid && m_slot.MemRead && (m_slot.RD != 0) &&
                   ((d.UsesRs1 && d.Rs1 == m_slot.RD) || (d.UsesRs2 && d.Rs2 == m_slot.RD));
        csr_raw  = valid && m_valid && m_slot.CSRWrite && (d.CSROp != 2'b00) &&
                   (d.CSRAddr == m_slot.CSRAddr);
        return (load_use || csr_raw) && !flush;
    endfunction

    // One cycle: present D, check stalls mid-cycle, advance the model at the edge, check E.
    task automatic applyStimulus(input slot_t s, input logic valid, input logic flush, input logic r);
        logic  exp_ilk;
        slot_t kept;
        driveD(s, valid, flush, r);
        exp_ilk = expectInterlock(s, valid, flush);
        #3;
        checkOutput("StallF", 256'(bus.StallF), 256'(exp_ilk));
        checkOutput("StallD", 256'(bus.StallD), 256'(exp_ilk));
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0;
            m_slot  = '0;
            m_count = 0;
        end else if (flush || exp_ilk) begin
            m_valid = 1'b0;
            m_slot  = '0;
            if (exp_ilk && m_count < int'(CNT_MAX)) m_count++;
        end else begin
            kept = s;
            if (!valid) begin
                kept.RegWrite   = 1'b0;
                kept.MemRead    = 1'b0;
                kept.MemWrite   = 1'b0;
                kept.Branch     = 1'b0;
                kept.Jump       = 1'b0;
                kept.CSRWrite   = 1'b0;
                kept.CSROp      = 2'b00;
                kept.ALUControl = 4'd0;
            end
            m_valid = valid;
            m_slot  = kept;
        end
        #1;
        checkOutput("ValidE", 256'(bus.ValidE), 256'(m_valid));
        checkOutput("slotE", 256'(observedE()), 256'(m_slot));
        checkOutput("BubbleCount", 256'(bus.BubbleCount), 256'(m_count));
    endtask

    slot_t ld, use_i, csr_w, csr_r;

    initial begin
        m_valid = 1'b0;
        m_slot  = '0;
        m_count = 0;

        driveD(randomSlot(), 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        driveD(randomSlot(), 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("reset_ValidE", 256'(bus.ValidE), 256'(0));
        checkOutput("reset_slotE", 256'(observedE()), 256'(0));
        checkOutput("reset_BubbleCount", 256'(bus.BubbleCount), 256'(0));
        applyStimulus(randomSlot(), 1'b1, 1'b0, 1'b1);

        ld          = '0;
        ld.MemRead  = 1'b1;
        ld.RegWrite = 1'b1;
        ld.RD       = 5'd5;
        ld.Rs1      = 5'd1;
        ld.UsesRs1  = 1'b1;
        use_i          = '0;
        use_i.RegWrite = 1'b1;
        use_i.UsesRs1  = 1'b1;
        use_i.UsesRs2  = 1'b1;
        use_i.Rs1      = 5'd5;
        use_i.Rs2      = 5'd7;
        use_i.RD       = 5'd6;
        use_i.PC       = 32'h100;

        // Classic load-use: one bubble, then the dependent instruction is captured.
        applyStimulus(ld, 1'b1, 1'b0, 1'b0);
        applyStimulus(use_i, 1'b1, 1'b0, 1'b0);
        checkOutput("lu_bubble_RegWriteE", 256'(bus.RegWriteE), 256'(0));
        applyStimulus(use_i, 1'b1, 1'b0, 1'b0);
        checkOutput("lu_captured_PCE", 256'(bus.PCE), 256'(32'h100));
        checkOutput("lu_BubbleCount", 256'(bus.BubbleCount), 256'(1));

        // Load to x0 and a consumer that ignores rs1 must not stall.
        ld.RD = 5'd0;
        applyStimulus(ld, 1'b1, 1'b0, 1'b0);
        use_i.Rs1 = 5'd0;
        applyStimulus(use_i, 1'b1, 1'b0, 1'b0);
        ld.RD = 5'd5;
        applyStimulus(ld, 1'b1, 1'b0, 1'b0);
        use_i.Rs1 = 5'd5;
        use_i.UsesRs1 = 1'b0;
        applyStimulus(use_i, 1'b1, 1'b0, 1'b0);
        use_i.UsesRs1 = 1'b1;

        // Store data via rs2 interlocks too.
        applyStimulus(ld, 1'b1, 1'b0, 1'b0);
        use_i.Rs1 = 5'd1;
        use_i.Rs2 = 5'd5;
        use_i.MemWrite = 1'b1;
        applyStimulus(use_i, 1'b1, 1'b0, 1'b0);
        checkOutput("store_rs2_BubbleCount", 256'(bus.BubbleCount), 256'(2));
        applyStimulus(use_i, 1'b1, 1'b0, 1'b0);

        // CSR read-after-write: same address stalls, different address does not.
        csr_w           = '0;
        csr_w.CSRWrite  = 1'b1;
        csr_w.CSROp     = 2'b01;
        csr_w.CSRAddr   = 12'h300;
        csr_r           = '0;
        csr_r.CSROp     = 2'b10;
        csr_r.CSRAddr   = 12'h300;
        csr_r.RegWrite  = 1'b1;
        applyStimulus(csr_w, 1'b1, 1'b0, 1'b0);
        applyStimulus(csr_r, 1'b1, 1'b0, 1'b0);
        checkOutput("csr_BubbleCount", 256'(bus.BubbleCount), 256'(3));
        applyStimulus(csr_r, 1'b1, 1'b0, 1'b0);
        applyStimulus(csr_w, 1'b1, 1'b0, 1'b0);
        csr_r.CSRAddr = 12'h305;
        applyStimulus(csr_r, 1'b1, 1'b0, 1'b0);

        // Flush wins over a pending load-use.
        use_i.Rs2 = 5'd5;
        applyStimulus(ld, 1'b1, 1'b0, 1'b0);
        applyStimulus(use_i, 1'b1, 1'b1, 1'b0);
        checkOutput("flush_ValidE", 256'(bus.ValidE), 256'(0));
        checkOutput("flush_BubbleCount", 256'(bus.BubbleCount), 256'(3));

        // Reset asserted while a stall is pending.
        applyStimulus(ld, 1'b1, 1'b0, 1'b0);
        applyStimulus(use_i, 1'b1, 1'b0, 1'b1);
        applyStimulus(use_i, 1'b1, 1'b0, 1'b1);
        applyStimulus(use_i, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 1500; i++)
            applyStimulus(randomSlot(), 1'($urandom_range(0, 7) != 0),
                          1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 63) == 0));

        // Drive the counter into saturation and keep pushing.
        for (int i = 0; i < int'(CNT_MAX) + 5; i++) begin
            applyStimulus(ld, 1'b1, 1'b0, 1'b0);
            applyStimulus(use_i, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("sat_BubbleCount", 256'(bus.BubbleCount), 256'(CNT_MAX));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/id_ex_pipeline_reg.md
Name: id_ex_pipeline_reg

Overview:
Decode-to-execute pipeline register for the 5-stage RV32 core with CSR support, in the decode_cycle directory.
- Captures the decoded control and operand bundle each cycle.
- Consumes FlushE from hazard_detection_unit.
- Generates the load-use and CSR read-after-write interlocks that forwarding cannot cover: stalls fetch/decode and inserts a bubble into execute.
- Keeps a saturating interlock-bubble counter for performance debug.

Parameters:
XLEN, 32, datapath width
BCNT_W, 16, width of the bubble counter

Ports:
clk  in  1  core clock, rising edge
rst  in  1  synchronous reset, active-high
FlushE  in  1  from hazard_detection_unit; kill instruction entering E
ValidD  in  1  decode slot holds a real instruction
RegWriteD, MemReadD, MemWriteD, ALUSrcD, BranchD, JumpD, CSRWriteD  in  1 each  decoded control
ALUControlD  in  4  ALU op select
CSROpD  in  2  00 none, 01 RW, 10 RS, 11 RC
CSRAddrD  in  12  CSR address
UsesRs1D, UsesRs2D  in  1 each  instruction reads rs1/rs2
Rs1_D, Rs2_D, RD_D  in  5 each  register indices
RD1_D, RD2_D, Imm_Ext_D, PCD, PCPlus4D  in  XLEN each  operands, immediate, PCs
<each D control/data signal>_E  out  same width  registered copy (RegWriteE ... PCPlus4E)
ValidE  out  1  execute slot valid
StallF, StallD  out  1 each  hold PC and IF/ID register
BubbleCount  out  BCNT_W  saturating count of interlock bubbles

Behaviour:
- All E outputs are registered; latency is 1 cycle D->E. StallF/StallD are combinational.
- Load-use condition (lu): ValidD & ValidE & MemReadE & RD_E!=0 & ((UsesRs1D & Rs1_D==RD_E) | (UsesRs2D & Rs2_D==RD_E)).
- CSR condition (cs): ValidD & ValidE & CSRWriteE & CSROpD!=00 & CSRAddrD==CSRAddrE.
- ilk = (lu | cs) & ~FlushE. StallF = StallD = ilk.
- Per-edge priority:
  - 1. rst: all E outputs, ValidE and BubbleCount go to 0.
  - 2. FlushE: bubble. ValidE=0, all control _E=0 (RegWriteE, MemReadE, MemWriteE, BranchE, JumpE, CSRWriteE, CSROpE, ALUControlE). Data _E are also zeroed. Counter unchanged.
  - 3. ilk: same bubble as a flush. BubbleCount increments by 1 and saturates at all-ones; no wrap.
  - 4. Otherwise: capture every D field. ValidE=ValidD. If ValidD=0, control _E is forced to 0.
- A bubble never asserts any write enable. RD_E=0 in a bubble, so forwarding never matches it.
- One stall cycle per load-use hazard. After the bubble, MemReadE=0, so the condition self-clears. The result then arrives via W forwarding.
- FlushE and ilk in the same cycle: flush wins and no stall is issued. The branch/jump redirect discards the D instruction anyway.
- rst held mid-stall: StallF/StallD drop once ValidE=0 (the cycle after reset). rst asserted over several cycles keeps everything at 0.
- x0 as destination never causes an interlock. A store reading the loaded register via rs2 does interlock (UsesRs2D=1).

Decomposition:
- Shared package pipeline_pkg:
  - XLEN
  - CSROp encodings (CSR_NONE/RW/RS/RC)
  - ALUControl width/encodings
  - a struct type for the D/E control bundle, reused by the E/M register
- Optional sub-module id_ex_interlock (combinational lu/cs/ilk generation), instantiated once. The register bank and counter stay in the top.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random D inputs -> all _E=0, ValidE=0, BubbleCount=0, StallF=StallD=0.
- Load-use: lw x5 in E (MemReadE=1, RD_E=5) and add x6,x5,x7 in D (Rs1_D=5, UsesRs1D=1) -> StallF=StallD=1 for exactly 1 cycle. Next cycle ValidE=0 and RegWriteE=0, then the add is captured; BubbleCount=1.
- x0/no-use: lw x0 in E with Rs1_D=0, or lw x5 with UsesRs1D=0 (lui) -> no stall, D captured next edge.
- CSR RAW: csrrw 0x300 in E (CSRWriteE=1) and csrrs reading 0x300 in D -> 1-cycle stall and bubble. Same scenario with address 0x305 -> no stall.
- Flush priority: load-use condition true and FlushE=1 together -> StallD=0, ValidE=0, all control _E=0 after the edge, BubbleCount unchanged.
- Saturation: preload via 65535 interlocks (BCNT_W=16) plus one more -> BubbleCount stays 16'hFFFF.
